// File: rtl/mdu.sv
// Multiply/divide unit for the MIPS E stage: owns HI/LO and models mult/div
// latency with a down-counter, committing the precomputed result on the last busy cycle.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic [31:0] r_res_hi, w_res_hi_nxt;
    logic [31:0] r_res_lo, w_res_lo_nxt;
    logic        r_div0, w_div0_nxt;

    // Full-width products.
    logic signed [63:0] w_a_sx, w_b_sx;
    logic [63:0]        w_prod_s, w_prod_u;

    assign w_a_sx   = {{32{A[31]}}, A};
    assign w_b_sx   = {{32{B[31]}}, B};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide runs on magnitudes so 0x80000000 / -1 cannot overflow;
    // a zero divisor is replaced by 1 because that result is never committed.
    logic [31:0] w_b_nz, w_a_mag, w_b_mag, w_q_mag, w_r_mag;
    logic [31:0] w_q_s, w_r_s, w_q_u, w_r_u;

    assign w_b_nz  = (B == 32'd0) ? 32'd1 : B;
    assign w_a_mag = A[31] ? (~A + 32'd1) : A;
    assign w_b_mag = B[31] ? (~B + 32'd1) : w_b_nz;
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;
    assign w_q_s   = (A[31] ^ B[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r_s   = A[31] ? (~w_r_mag + 32'd1) : w_r_mag;
    assign w_q_u   = A / w_b_nz;
    assign w_r_u   = A % w_b_nz;

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_res_hi_nxt = r_res_hi;
        w_res_lo_nxt = r_res_lo;
        w_div0_nxt   = r_div0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            w_res_hi_nxt = (op == OP_MULT) ? w_prod_s[63:32] : w_prod_u[63:32];
                            w_res_lo_nxt = (op == OP_MULT) ? w_prod_s[31:0]  : w_prod_u[31:0];
                            w_div0_nxt   = 1'b0;
                            w_cnt_nxt    = 32'(MULT_CYCLES);
                            w_state_nxt  = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_res_hi_nxt = (op == OP_DIV) ? w_r_s : w_r_u;
                            w_res_lo_nxt = (op == OP_DIV) ? w_q_s : w_q_u;
                            w_div0_nxt   = (B == 32'd0);
                            w_cnt_nxt    = 32'(DIV_CYCLES);
                            w_state_nxt  = S_RUN;
                        end
                        OP_MTHI: w_hi_nxt = A;
                        OP_MTLO: w_lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (r_cnt == 32'd1) begin
                    if (!r_div0) begin
                        w_hi_nxt = r_res_hi;
                        w_lo_nxt = r_res_lo;
                    end
                    w_cnt_nxt   = 32'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the pending
    // result registers are reset too so a discarded operation leaves nothing behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_div0   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_res_hi <= w_res_hi_nxt;
            r_res_lo <= w_res_lo_nxt;
            r_div0   <= w_div0_nxt;
        end
    end

    assign busy = (r_state == S_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
